// File: rtl/tdc_echo_capture_pkg.sv
// Shared types and widths for the echo time-to-digital capture block.
package tdc_echo_capture_pkg;

   localparam int TDC_W  = 15;
   localparam int TCNT_W = 32;
   localparam int MISS_W = 16;
   localparam int CNT_W  = 16;
   localparam int AGR_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_START = 2'd1,
      ST_MEASURE    = 2'd2
   } state_e;

   function automatic logic [15:0] abs16(input logic signed [15:0] v);
      abs16 = (v < 16'sd0) ? -v : v;
   endfunction

   function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
      sat_inc_miss = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/tdc_echo_capture_rise_detect.sv
// Single-bit rising-edge detector: the edge is reported in the same cycle the input goes high.
module rise_detect
   import tdc_echo_capture_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   // Next value of the previous-sample register.
   always_comb begin
      prev_d = d;
   end

   // Previous-sample register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = d & ~prev_q;

endmodule

// File: rtl/tdc_echo_capture.sv
// Measures tstart-to-echo intervals, filters them by agreement and publishes confirmed delays.
module tdc_echo_capture
   import tdc_echo_capture_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              tstart,
   input  logic              ch1,
   input  logic [14:0]       timeout,
   input  logic [14:0]       offset,
   input  logic [7:0]        tolerance,
   input  logic [3:0]        confirm_count,
   output logic [TDC_W-1:0]  tdc_data,
   output logic              tdc_data_flag,
   output logic [TCNT_W-1:0] tstart_count,
   output logic [MISS_W-1:0] miss_count,
   output logic              busy
);

   logic tstart_rise;
   logic ch1_rise;

   state_e             state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [AGR_W-1:0]   agree_q,  agree_d;
   logic [TDC_W-1:0]   cand_q,   cand_d;
   logic [TDC_W-1:0]   data_q,   data_d;
   logic               flag_q,   flag_d;
   logic [TCNT_W-1:0]  tcnt_q,   tcnt_d;
   logic [MISS_W-1:0]  miss_q,   miss_d;
   logic               busy_q,   busy_d;

   logic signed [15:0] diff_s;
   logic signed [15:0] dev_s;
   logic [TDC_W-1:0]   result_s;
   logic [AGR_W-1:0]   target_s;
   logic               close_s;
   logic [AGR_W-1:0]   new_agree_s;

   rise_detect u_tstart_rise (
      .clk    (clk),
      .resetn (resetn),
      .d      (tstart),
      .rise   (tstart_rise)
   );

   rise_detect u_ch1_rise (
      .clk    (clk),
      .resetn (resetn),
      .d      (ch1),
      .rise   (ch1_rise)
   );

   // cnt_q equals the cycles elapsed since the tstart rise, so it is the raw interval directly.
   assign diff_s   = $signed(cnt_q) - $signed({1'b0, offset});
   assign result_s = diff_s[15] ? {TDC_W{1'b0}} : diff_s[TDC_W-1:0];
   assign dev_s    = $signed({1'b0, result_s}) - $signed({1'b0, cand_q});
   assign close_s  = (agree_q != 5'd0) && (abs16(dev_s) <= {8'd0, tolerance});
   assign target_s = (confirm_count == 4'd0) ? 5'd1 : {1'b0, confirm_count};

   // Next-state, measurement and agreement logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      agree_d     = agree_q;
      cand_d      = cand_q;
      data_d      = data_q;
      flag_d      = 1'b0;
      miss_d      = miss_q;
      new_agree_s = 5'd0;
      if (tstart_rise) begin
         tcnt_d = tcnt_q + 32'd1;
      end else begin
         tcnt_d = tcnt_q;
      end
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = 16'd0;
         agree_d = 5'd0;
         cand_d  = {TDC_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (tstart_rise) begin
                  state_d = ST_MEASURE;
                  cnt_d   = 16'd1;
               end else begin
                  state_d = ST_WAIT_START;
               end
            end
            ST_MEASURE: begin
               if (tstart_rise) begin
                  miss_d  = sat_inc_miss(miss_q);
                  agree_d = 5'd0;
                  cnt_d   = 16'd1;
               end else if (ch1_rise) begin
                  state_d = ST_WAIT_START;
                  cnt_d   = 16'd0;
                  cand_d  = result_s;
                  if (close_s) begin
                     new_agree_s = agree_q + 5'd1;
                  end else begin
                     new_agree_s = 5'd1;
                  end
                  if (new_agree_s >= target_s) begin
                     data_d  = result_s;
                     flag_d  = 1'b1;
                     agree_d = 5'd0;
                  end else begin
                     agree_d = new_agree_s;
                  end
               end else if (cnt_q >= {1'b0, timeout}) begin
                  miss_d  = sat_inc_miss(miss_q);
                  agree_d = 5'd0;
                  state_d = ST_WAIT_START;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
            end
         endcase
      end
      busy_d = (state_d == ST_MEASURE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         agree_q <= 5'd0;
         cand_q  <= {TDC_W{1'b0}};
         data_q  <= {TDC_W{1'b0}};
         flag_q  <= 1'b0;
         tcnt_q  <= 32'd0;
         miss_q  <= 16'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         agree_q <= agree_d;
         cand_q  <= cand_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         tcnt_q  <= tcnt_d;
         miss_q  <= miss_d;
         busy_q  <= busy_d;
      end
   end

   assign tdc_data      = data_q;
   assign tdc_data_flag = flag_q;
   assign tstart_count  = tcnt_q;
   assign miss_count    = miss_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_tdc_echo_capture.sv
// Self-checking bench for tdc_echo_capture: vector table, corner sequences and random traffic vs a cycle-index model.
module tb_tdc_echo_capture;

   logic        clk = 1'b0;
   logic        resetn, enable, tstart, ch1;
   logic [14:0] timeout, offset;
   logic [7:0]  tolerance;
   logic [3:0]  confirm_count;
   logic [14:0] tdc_data;
   logic        tdc_data_flag;
   logic [31:0] tstart_count;
   logic [15:0] miss_count;
   logic        busy;

   tdc_echo_capture dut (
      .clk           (clk),
      .resetn        (resetn),
      .enable        (enable),
      .tstart        (tstart),
      .ch1           (ch1),
      .timeout       (timeout),
      .offset        (offset),
      .tolerance     (tolerance),
      .confirm_count (confirm_count),
      .tdc_data      (tdc_data),
      .tdc_data_flag (tdc_data_flag),
      .tstart_count  (tstart_count),
      .miss_count    (miss_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: intervals are differences of absolute cycle indices.
   longint      m_cyc = 0;
   longint      m_t0  = 0;
   int          m_mode = 0;   // 0 idle, 1 waiting for tstart, 2 measuring
   int          m_agree = 0;
   int          m_cand = 0;
   bit          m_pts = 1'b0, m_pc1 = 1'b0;
   logic [14:0] e_data = '0;
   logic        e_flag = 1'b0;
   logic [31:0] e_tcnt = '0;
   int          e_miss = 0;
   logic        e_busy = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_miss();
      if (e_miss < 65535) e_miss++;
      m_agree = 0;
   endfunction

   function automatic void model_edge();
      bit tr, cr;
      int el, res, d, tgt;
      if (!resetn) begin
         m_mode = 0; m_agree = 0; m_cand = 0; m_pts = 1'b0; m_pc1 = 1'b0;
         e_data = '0; e_flag = 1'b0; e_tcnt = '0; e_miss = 0; e_busy = 1'b0;
         m_cyc++;
         return;
      end
      tr = tstart && !m_pts;
      cr = ch1 && !m_pc1;
      m_pts = tstart;
      m_pc1 = ch1;
      if (tr) e_tcnt = e_tcnt + 32'd1;
      e_flag = 1'b0;
      if (!enable) begin
         m_mode = 0;
         m_agree = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (tr) begin
            m_mode = 2;
            m_t0 = m_cyc;
         end
      end else begin
         el = int'(m_cyc - m_t0);
         if (tr) begin
            model_miss();
            m_t0 = m_cyc;
         end else if (cr) begin
            res = el - int'(offset);
            if (res < 0) res = 0;
            d = res - m_cand;
            if (d < 0) d = -d;
            if (m_agree == 0 || d > int'(tolerance)) m_agree = 1;
            else m_agree++;
            m_cand = res;
            tgt = (confirm_count == 4'd0) ? 1 : int'(confirm_count);
            if (m_agree >= tgt) begin
               e_data = 15'(res);
               e_flag = 1'b1;
               m_agree = 0;
            end
            m_mode = 1;
         end else if (el >= int'(timeout)) begin
            model_miss();
            m_mode = 1;
         end
      end
      e_busy = (m_mode == 2);
      m_cyc++;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("data",   tdc_data,      e_data);
      chk("flag",   tdc_data_flag, e_flag);
      chk("tcount", tstart_count,  e_tcnt);
      chk("miss",   miss_count,    16'(e_miss));
      chk("busy",   busy,          e_busy);
   endtask

   // tstart rise on one cycle, ch1 rise exactly raw cycles later.
   task automatic hit(input int raw);
      tstart = 1'b1; ch1 = 1'b0; step();
      tstart = 1'b0;
      repeat (raw - 1) step();
      ch1 = 1'b1; step();
      ch1 = 1'b0;
   endtask

   typedef struct {
      int off;
      int raw;
      int exp_data;
   } vec_t;

   vec_t vt[9];

   initial begin
      vt[0] = '{0,   1000, 1000};
      vt[1] = '{50,  30,   0};
      vt[2] = '{50,  80,   30};
      vt[3] = '{50,  50,   0};
      vt[4] = '{0,   1,    1};
      vt[5] = '{100, 101,  1};
      vt[6] = '{7,   7,    0};
      vt[7] = '{0,   4000, 4000};
      vt[8] = '{3,   250,  247};

      resetn = 1'b0; enable = 1'b0; tstart = 1'b0; ch1 = 1'b0;
      timeout = 15'h7FFF; offset = '0; tolerance = '0; confirm_count = 4'd1;
      #2;
      step(); step();
      chk("rst_data", tdc_data, 0);
      chk("rst_flag", tdc_data_flag, 0);
      chk("rst_tcount", tstart_count, 0);
      chk("rst_miss", miss_count, 0);
      chk("rst_busy", busy, 0);

      resetn = 1'b1; enable = 1'b1;
      step(); step();

      // Single-shot measurements with confirm=1.
      for (int i = 0; i < 9; i++) begin
         offset = 15'(vt[i].off);
         step();
         hit(vt[i].raw);
         chk("tbl_data", tdc_data, vt[i].exp_data);
         chk("tbl_flag", tdc_data_flag, 1);
         step();
         chk("tbl_flag_drop", tdc_data_flag, 0);
      end

      // Agreement: only the fifth result completes three agreeing results.
      offset = '0; confirm_count = 4'd3; tolerance = 8'd2;
      begin
         int raws[5] = '{3000, 3001, 3005, 3004, 3003};
         for (int k = 0; k < 5; k++) begin
            step();
            hit(raws[k]);
            chk((k < 4) ? "agr_noflag" : "agr_flag", tdc_data_flag, (k < 4) ? 0 : 1);
         end
         chk("agr_data", tdc_data, 3003);
      end

      // Timeout at exactly 500 cycles, then a normal measurement.
      confirm_count = 4'd1; timeout = 15'd500;
      step();
      tstart = 1'b1; step(); tstart = 1'b0;
      repeat (499) step();
      chk("to_busy_before", busy, 1);
      chk("to_miss_before", miss_count, 0);
      step();
      chk("to_miss", miss_count, 1);
      chk("to_busy_after", busy, 0);
      step();
      hit(120);
      chk("to_next_data", tdc_data, 120);

      // Second tstart 200 cycles into MEASURE restarts the interval.
      timeout = 15'h7FFF;
      step();
      tstart = 1'b1; step(); tstart = 1'b0;
      repeat (199) step();
      tstart = 1'b1; step(); tstart = 1'b0;
      chk("restart_miss", miss_count, 2);
      chk("restart_busy", busy, 1);
      repeat (99) step();
      ch1 = 1'b1; step(); ch1 = 1'b0;
      chk("restart_data", tdc_data, 100);
      chk("restart_flag", tdc_data_flag, 1);

      // Reset mid-measure, then tstart counting while disabled.
      step();
      tstart = 1'b1; step(); tstart = 1'b0;
      repeat (50) step();
      ch1 = 1'b1; resetn = 1'b0; step();
      chk("mrst_data", tdc_data, 0);
      chk("mrst_flag", tdc_data_flag, 0);
      chk("mrst_tcount", tstart_count, 0);
      chk("mrst_miss", miss_count, 0);
      chk("mrst_busy", busy, 0);
      resetn = 1'b1; enable = 1'b0; ch1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tstart = 1'b1; step();
         tstart = 1'b0; ch1 = 1'b1; step();
         ch1 = 1'b0;
      end
      chk("dis_tcount", tstart_count, 3);
      chk("dis_busy", busy, 0);
      chk("dis_data", tdc_data, 0);

      // Random traffic against the model.
      for (int c = 0; c < 20000; c++) begin
         if (c % 400 == 0) begin
            offset        = 15'($urandom_range(0, 40));
            tolerance     = 8'($urandom_range(0, 60));
            confirm_count = 4'($urandom_range(0, 3));
            timeout       = 15'($urandom_range(0, 150));
         end
         resetn = ($urandom_range(0, 2999) != 0);
         enable = ($urandom_range(0, 149) != 0);
         tstart = ($urandom_range(0, 49) == 0);
         ch1    = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
